// File: rtl/codma_mem_slave.sv
// codma_mem_slave: single-port 64-bit memory slave on the DMA bus with burst reads and writes.
// Optional macro CODMA_MEM_STALL_EN adds LFSR-driven gaps between read beats.
module codma_mem_slave #(
  parameter int MEM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2,
  localparam int AW          = $clog2(MEM_DEPTH)
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        bus_read_i,
  input  logic        bus_write_i,
  input  logic [31:0] bus_addr_i,
  input  logic [3:0]  bus_size_i,
  input  logic [63:0] bus_wdata_i,
  input  logic        bus_wvalid_i,
  output logic        bus_grant_o,
  output logic        bus_read_valid_o,
  output logic [63:0] bus_read_data_o,
  output logic        busy_o
);

  if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..7");
  end
  if (MEM_DEPTH < 16 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("MEM_DEPTH must be a power of two, at least 16");
  end

  // Handshake: the master holds bus_read_i/bus_write_i until a one-cycle bus_grant_o;
  // read beats are presented with bus_read_valid_o (no back-pressure), write beats are
  // taken on every WR_BURST cycle with bus_wvalid_i high.
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [3:0]      left_q, left_d;
  logic [2:0]      lat_q, lat_d;
  logic            grant_q, grant_d;
  logic [63:0]     hold_q, hold_d;
  logic            rd_valid;
  logic            mem_we;
  logic            stall;
  logic [63:0]     rd_word;
  logic [63:0]     mem [MEM_DEPTH];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus_addr_i[31:AW+3], bus_addr_i[2:0]};

  function automatic logic [3:0] beats_of(input logic [3:0] size);
    if (size <= 4'd3)      return 4'd1;
    else if (size == 4'd4) return 4'd2;
    else if (size == 4'd5) return 4'd4;
    else                   return 4'd8;
  endfunction

`ifdef CODMA_MEM_STALL_EN
  logic [7:0] lfsr_q;
  // Fibonacci form of x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  always_ff @(posedge clk_i) begin
    if (reset_i) lfsr_q <= 8'hA5;
    else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign rd_word = mem[idx_q];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    left_d   = left_q;
    lat_d    = lat_q;
    grant_d  = 1'b0;
    hold_d   = hold_q;
    rd_valid = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_read_i || bus_write_i) begin
          grant_d = 1'b1;
          idx_d   = bus_addr_i[AW+2:3];
          left_d  = beats_of(bus_size_i);
          lat_d   = 3'd1;
          state_d = bus_read_i ? RD_WAIT : WR_BURST;
        end
      end
      RD_WAIT: begin
        // The grant cycle counts as latency cycle 1.
        if (lat_q == LAT) state_d = RD_BURST;
        else              lat_d   = lat_q + 3'd1;
      end
      RD_BURST: begin
        if (!stall) begin
          rd_valid = 1'b1;
          hold_d   = rd_word;
          idx_d    = idx_q + AW'(1);
          left_d   = left_q - 4'd1;
          if (left_q == 4'd1) state_d = IDLE;
        end
      end
      WR_BURST: begin
        if (bus_wvalid_i) begin
          mem_we = 1'b1;
          idx_d  = idx_q + AW'(1);
          left_d = left_q - 4'd1;
          if (left_q == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      left_q  <= '0;
      lat_q   <= '0;
      grant_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      lat_q   <= lat_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[idx_q] <= bus_wdata_i;
  end

  assign bus_grant_o      = grant_q;
  assign bus_read_valid_o = rd_valid;
  assign bus_read_data_o  = rd_valid ? rd_word : hold_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_codma_mem_slave.sv
// tb_codma_mem_slave: vector table, directed corner cases and random traffic
// for codma_mem_slave, checked against a word-array memory model.
module tb_codma_mem_slave;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        bus_read_i, bus_write_i, bus_wvalid_i;
  logic [31:0] bus_addr_i;
  logic [3:0]  bus_size_i;
  logic [63:0] bus_wdata_i;
  logic        bus_grant_o, bus_read_valid_o, busy_o;
  logic [63:0] bus_read_data_o;

  codma_mem_slave #(.MEM_DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .bus_read_i(bus_read_i), .bus_write_i(bus_write_i),
    .bus_addr_i(bus_addr_i), .bus_size_i(bus_size_i),
    .bus_wdata_i(bus_wdata_i), .bus_wvalid_i(bus_wvalid_i),
    .bus_grant_o(bus_grant_o), .bus_read_valid_o(bus_read_valid_o),
    .bus_read_data_o(bus_read_data_o), .busy_o(busy_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout no_finish got=running exp=finished");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] ref_mem [DEPTH];
  logic [63:0] wbuf [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    if (bus_read_valid_o === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_read_beat", 1, 0);
      else check("read_data", bus_read_data_o, exp_q.pop_front());
    end
  end

  // ---------------- model helpers ----------------
  function automatic int beats_of(input logic [3:0] size);
    if (size < 4) return 1;
    if (size == 4) return 2;
    if (size == 5) return 4;
    return 8;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    logic [31:0] w;
    w = addr >> 3;
    return int'(w % DEPTH);
  endfunction

  task automatic check_lat(input string name, input int got);
`ifdef CODMA_MEM_STALL_EN
    check(name, got >= LAT, 1);
`else
    check(name, got, LAT);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_grant(output int waited);
    waited = 0;
    do begin
      @(negedge clk_i);
      waited++;
    end while (!bus_grant_o && waited < 50);
    check("grant_seen", bus_grant_o, 1);
    check("busy_in_grant_cycle", busy_o, 1);
  endtask

  task automatic fill_wbuf();
    for (int i = 0; i < 8; i++) wbuf[i] = {$urandom(), $urandom()};
  endtask

  // Called at the negedge of the grant cycle; gap_mode 0=none, 1=random, 2=gap before beat 1.
  task automatic write_beats(input int base, input int n, input int gap_mode);
    for (int i = 0; i < n; i++) begin
      if ((gap_mode == 1 && $urandom_range(0, 1) == 1) || (gap_mode == 2 && i == 1)) begin
        bus_wvalid_i = 1'b0;
        bus_wdata_i  = {$urandom(), $urandom()};
        @(negedge clk_i);
        check("wr_busy_in_gap", busy_o, 1);
      end
      bus_wvalid_i = 1'b1;
      bus_wdata_i  = wbuf[i];
      ref_mem[(base + i) % DEPTH] = wbuf[i];
      @(negedge clk_i);
    end
    bus_wvalid_i = 1'b0;
    check("wr_busy_done", busy_o, 0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] size, input int gap_mode);
    int w;
    bus_addr_i  = addr;
    bus_size_i  = size;
    bus_write_i = 1'b1;
    wait_grant(w);
    check("wr_grant_latency", w, 1);
    bus_write_i = 1'b0;
    write_beats(widx(addr), beats_of(size), gap_mode);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] size, input int n,
                         output int span);
    int w, g, got, t, first_c, last_c, base;
    logic [63:0] last_exp;
    base = widx(addr);
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(base + i) % DEPTH]);
    last_exp    = ref_mem[(base + n - 1) % DEPTH];
    bus_addr_i  = addr;
    bus_size_i  = size;
    bus_read_i  = 1'b1;
    wait_grant(w);
    check("rd_grant_latency", w, 1);
    g = cyc;
    bus_read_i = 1'b0;
    got = 0; t = 0; first_c = 0; last_c = 0;
    while (got < n && t < 200) begin
      @(negedge clk_i);
      t++;
      if (bus_read_valid_o) begin
        if (got == 0) first_c = cyc;
        got++;
        last_c = cyc;
      end
    end
    span = last_c - first_c + 1;
    check("read_beat_count", got, n);
    check_lat("read_first_latency", first_c - g);
`ifndef CODMA_MEM_STALL_EN
    check("read_back_to_back", span, n);
`endif
    @(negedge clk_i);
    check("read_busy_done", busy_o, 0);
    check("read_data_hold", bus_read_data_o, last_exp);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [3:0] size;
    int         exp_beats;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int span, got, t, g, first_c, last_c, early;
    logic [31:0] addr;
    logic [3:0]  sz;

    vecs[0] = '{4'd0, 1};  vecs[1] = '{4'd1, 1};  vecs[2] = '{4'd2, 1};
    vecs[3] = '{4'd3, 1};  vecs[4] = '{4'd4, 2};  vecs[5] = '{4'd5, 4};
    vecs[6] = '{4'd6, 8};  vecs[7] = '{4'd7, 8};  vecs[8] = '{4'd8, 8};
    vecs[9] = '{4'd15, 8};

    reset_i = 1'b1; bus_read_i = 1'b0; bus_write_i = 1'b0; bus_wvalid_i = 1'b0;
    bus_addr_i = '0; bus_size_i = '0; bus_wdata_i = '0;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    check("rst_grant", bus_grant_o, 0);
    check("rst_read_valid", bus_read_valid_o, 0);
    check("rst_read_data", bus_read_data_o, 0);
    check("rst_busy", busy_o, 0);

    // Give every word a known value.
    for (int k = 0; k < DEPTH / 8; k++) begin
      fill_wbuf();
      do_write(32'(k * 64), 4'd6, 0);
    end

    // Preload mem[0..3] and read back as a 4-beat burst.
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h1111_0000_0000_0000 + 64'(i + 1);
    do_write(32'h0, 4'd5, 0);

    // wvalid with no burst open must not touch memory.
    bus_wvalid_i = 1'b1;
    bus_wdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (3) @(negedge clk_i);
    bus_wvalid_i = 1'b0;
    check("idle_wvalid_busy", busy_o, 0);
    do_read(32'h0, 4'd5, 4, span);

    // Two-beat write with an idle gap, then read back.
    wbuf[0] = 64'hAAAA_AAAA_0000_0008;
    wbuf[1] = 64'hBBBB_BBBB_0000_0009;
    do_write(32'h40, 4'd4, 2);
    do_read(32'h40, 4'd4, 2, span);

    // Wrap from the top of memory back to word 0.
    do_read(32'((DEPTH - 2) * 8), 4'd5, 4, span);

    // Beat count table.
    for (int v = 0; v < 10; v++)
      do_read(32'($urandom_range(0, DEPTH - 1) * 8), vecs[v].size, vecs[v].exp_beats, span);

    // Simultaneous read and write: read first, write granted two cycles after the last read beat.
    for (int i = 0; i < 4; i++) exp_q.push_back(ref_mem[(32 + i) % DEPTH]);
    bus_addr_i = 32'h100; bus_size_i = 4'd5;
    bus_read_i = 1'b1; bus_write_i = 1'b1;
    @(negedge clk_i);
    check("both_first_grant", bus_grant_o, 1);
    g = cyc;
    bus_read_i = 1'b0;
    got = 0; t = 0; first_c = 0; last_c = 0; early = 0;
    while (got < 4 && t < 100) begin
      @(negedge clk_i);
      t++;
      if (bus_grant_o) early++;
      if (bus_read_valid_o) begin
        if (got == 0) first_c = cyc;
        got++;
        last_c = cyc;
      end
    end
    check("both_read_beats", got, 4);
    check_lat("both_read_latency", first_c - g);
    check("both_no_regrant_in_burst", early, 0);
    t = 0;
    do begin
      @(negedge clk_i);
      t++;
    end while (!bus_grant_o && t < 50);
    check("both_write_grant", bus_grant_o, 1);
    check("both_turnaround", cyc - last_c, 2);
    bus_write_i = 1'b0;
    fill_wbuf();
    write_beats(32, 4, 0);
    do_read(32'h100, 4'd5, 4, span);

    // Reset after the second beat of a 4-beat read.
    for (int i = 0; i < 4; i++) exp_q.push_back(ref_mem[(16 + i) % DEPTH]);
    bus_addr_i = 32'h80; bus_size_i = 4'd5; bus_read_i = 1'b1;
    @(negedge clk_i);
    check("rst_mid_grant", bus_grant_o, 1);
    bus_read_i = 1'b0;
    got = 0; t = 0;
    while (got < 2 && t < 50) begin
      @(negedge clk_i);
      t++;
      if (bus_read_valid_o) got++;
    end
    check("rst_mid_two_beats", got, 2);
    reset_i = 1'b1;
    @(negedge clk_i);
    check("rst_mid_valid", bus_read_valid_o, 0);
    check("rst_mid_grant_low", bus_grant_o, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_data", bus_read_data_o, 0);
    reset_i = 1'b0;
    exp_q.delete();
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (bus_read_valid_o) got++;
    end
    check("rst_mid_no_more_beats", got, 0);
    do_read(32'h80, 4'd5, 4, span);

`ifdef CODMA_MEM_STALL_EN
    for (int i = 0; i < 8; i++) wbuf[i] = 64'h5A5A_0000_0000_0000 + 64'(i);
    do_write(32'h0, 4'd6, 0);
    do_read(32'h0, 4'd6, 8, span);
    check("stall_gap_seen", span > 8, 1);
`endif

    // Random traffic against the word-array model.
    for (int i = 0; i < 40; i++) begin
      addr = $urandom();
      sz   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        fill_wbuf();
        do_write(addr, sz, 1);
      end else begin
        do_read(addr, sz, beats_of(sz), span);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
